// File: rtl/spi_initiator_pkg.sv
// rtl/spi_initiator_pkg.sv - shared state encoding and counter sizing for spi_initiator
package spi_initiator_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_LOW   = 3'd2,
      ST_HIGH  = 3'd3,
      ST_CHAIN = 3'd4,
      ST_TAIL  = 3'd5,
      ST_GAP   = 3'd6
   } spi_state_t;

   // The phase timer holds (length - 1) of the longest phase, so it needs clog2 of the max length.
   function automatic int phase_cnt_width(input int clk_div, input int cs_setup,
                                          input int cs_hold, input int cs_gap);
      int m;
      m = clk_div;
      if (cs_setup > m) m = cs_setup;
      if (cs_hold > m)  m = cs_hold;
      if (cs_gap > m)   m = cs_gap;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/spi_initiator_timer.sv
// rtl/spi_initiator_timer.sv - loadable down-counter with done flag shared by all timed phases
module spi_initiator_timer #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);

   logic [WIDTH-1:0] cnt;

   // Load on phase entry, otherwise count down and park at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/spi_initiator.sv
// rtl/spi_initiator.sv - SPI mode-0 initiator, MSB first, with ready/valid word interface
module spi_initiator
   import spi_initiator_pkg::*;
#(
   parameter int WORD_BITS = 64,
   parameter int CLK_DIV   = 4,
   parameter int CS_SETUP  = 2,
   parameter int CS_HOLD   = 2,
   parameter int CS_GAP    = 2
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic [WORD_BITS-1:0] tx_word,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic                 hold_cs,
   output logic [WORD_BITS-1:0] rx_word,
   output logic                 rx_valid,
   output logic                 busy,
   output logic                 SCK,
   output logic                 CS,
   output logic                 COPI,
   input  logic                 CIPO
);

   localparam int TW = phase_cnt_width(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP);
   localparam int BW = $clog2(WORD_BITS);

   // Timer values are (phase length - 1): the entry cycle counts as the first cycle.
   localparam logic [TW-1:0] T_DIV   = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0] T_SETUP = TW'(CS_SETUP - 1);
   localparam logic [TW-1:0] T_HOLD  = TW'(CS_HOLD - 1);
   localparam logic [TW-1:0] T_GAP   = TW'(CS_GAP - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);

   spi_state_t           state;
   logic [WORD_BITS-1:0] tx_shift;
   logic [WORD_BITS-1:0] rx_shift;
   logic [BW-1:0]        bit_cnt;
   logic                 hold_lat;
   logic                 accept;
   logic                 tmr_load;
   logic [TW-1:0]        tmr_val;
   logic                 tmr_done;

   assign accept = tx_valid && tx_ready;
   assign busy   = (state != ST_IDLE);

   spi_initiator_timer #(.WIDTH(TW)) u_timer (
      .clk      (CLK),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Arm the timer with the length of whichever phase is entered on this edge.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = T_DIV;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               tmr_load = 1'b1;
               tmr_val  = T_SETUP;
            end
         end
         ST_SETUP, ST_LOW: begin
            if (tmr_done) tmr_load = 1'b1;
         end
         ST_HIGH: begin
            if (tmr_done) begin
               tmr_load = 1'b1;
               if (bit_cnt == '0) tmr_val = T_HOLD;
            end
         end
         ST_CHAIN: begin
            if (accept) begin
               tmr_load = 1'b1;
            end else if (!tx_valid && !hold_cs) begin
               tmr_load = 1'b1;
               tmr_val  = T_HOLD;
            end
         end
         ST_TAIL: begin
            if (tmr_done) begin
               tmr_load = 1'b1;
               tmr_val  = T_GAP;
            end
         end
         default: ;
      endcase
   end

   // Walk CS/SCK/COPI through the transfer phases; CIPO is captured as SCK rises.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state    <= ST_IDLE;
         CS       <= 1'b1;
         SCK      <= 1'b0;
         COPI     <= 1'b0;
         tx_ready <= 1'b0;
         rx_word  <= '0;
         rx_valid <= 1'b0;
         tx_shift <= '0;
         rx_shift <= '0;
         bit_cnt  <= '0;
         hold_lat <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               tx_ready <= 1'b1;
               if (accept) begin
                  tx_shift <= tx_word;
                  hold_lat <= hold_cs;
                  bit_cnt  <= LAST_BIT;
                  COPI     <= tx_word[WORD_BITS-1];
                  CS       <= 1'b0;
                  tx_ready <= 1'b0;
                  state    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (tmr_done) state <= ST_LOW;
            end
            ST_LOW: begin
               if (tmr_done) begin
                  SCK      <= 1'b1;
                  rx_shift <= {rx_shift[WORD_BITS-2:0], CIPO};
                  state    <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (tmr_done) begin
                  SCK <= 1'b0;
                  if (bit_cnt != '0) begin
                     tx_shift <= tx_shift << 1;
                     COPI     <= tx_shift[WORD_BITS-2];
                     bit_cnt  <= bit_cnt - 1'b1;
                     state    <= ST_LOW;
                  end else begin
                     rx_word  <= rx_shift;
                     rx_valid <= 1'b1;
                     if (hold_lat) begin
                        tx_ready <= 1'b1;
                        state    <= ST_CHAIN;
                     end else begin
                        state <= ST_TAIL;
                     end
                  end
               end
            end
            ST_CHAIN: begin
               if (accept) begin
                  tx_shift <= tx_word;
                  hold_lat <= hold_cs;
                  bit_cnt  <= LAST_BIT;
                  COPI     <= tx_word[WORD_BITS-1];
                  tx_ready <= 1'b0;
                  state    <= ST_LOW;
               end else if (!tx_valid && !hold_cs) begin
                  tx_ready <= 1'b0;
                  state    <= ST_TAIL;
               end
            end
            ST_TAIL: begin
               if (tmr_done) begin
                  CS    <= 1'b1;
                  state <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (tmr_done) begin
                  tx_ready <= 1'b1;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_initiator.sv
// tb/tb_spi_initiator.sv - self-checking bench for spi_initiator
module tb_spi_initiator;

   localparam int W  = 64;
   localparam int CD = 4;
   localparam int SU = 2;
   localparam int HO = 2;
   localparam int GP = 2;

   typedef struct packed {
      logic [W-1:0] w;
      logic         h;
   } item_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [W-1:0] tx_word;
   logic         tx_valid, tx_ready, hold_cs;
   logic [W-1:0] rx_word;
   logic         rx_valid, busy, sck, cs, copi, cipo;
   int           cipo_mode;

   assign cipo = (cipo_mode == 0) ? copi : (cipo_mode == 1) ? ~copi : 1'b1;

   logic [7:0] s_tx_word, s_rx_word;
   logic       s_tx_valid, s_tx_ready, s_hold, s_rx_valid, s_busy, s_sck, s_cs, s_copi, s_cipo;
   assign s_cipo = 1'b1;

   spi_initiator #(.WORD_BITS(W), .CLK_DIV(CD), .CS_SETUP(SU), .CS_HOLD(HO), .CS_GAP(GP)) u_dut (
      .CLK(clk), .reset(reset), .tx_word(tx_word), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .hold_cs(hold_cs), .rx_word(rx_word), .rx_valid(rx_valid), .busy(busy),
      .SCK(sck), .CS(cs), .COPI(copi), .CIPO(cipo)
   );

   spi_initiator #(.WORD_BITS(8), .CLK_DIV(1), .CS_SETUP(SU), .CS_HOLD(HO), .CS_GAP(GP)) u_small (
      .CLK(clk), .reset(reset), .tx_word(s_tx_word), .tx_valid(s_tx_valid), .tx_ready(s_tx_ready),
      .hold_cs(s_hold), .rx_word(s_rx_word), .rx_valid(s_rx_valid), .busy(s_busy),
      .SCK(s_sck), .CS(s_cs), .COPI(s_copi), .CIPO(s_cipo)
   );

   int checks = 0;
   int errors = 0;

   // Observation state, rebuilt from pin activity only.
   item_t        txq[$];
   logic         live_hold;
   logic [W-1:0] rxq[$];
   int           low_len[$], hold_gap[$], high_len[$], start_gap[$];
   int           cyc = 0, rises, cs_falls, cs_fall_at, cs_rise_at, ref_cyc, last_fall, gap_ready_bad;
   logic [127:0] copi_bits;
   logic         p_sck, p_cs, p_ready, seen_busy;

   task automatic clear_stats();
      rises = 0; cs_falls = 0; cs_fall_at = 0; cs_rise_at = -1; ref_cyc = 0; last_fall = 0;
      gap_ready_bad = 0; copi_bits = '0; seen_busy = 1'b0;
      rxq.delete(); low_len.delete(); hold_gap.delete(); high_len.delete(); start_gap.delete();
      p_sck = sck; p_cs = cs;
   endtask

   // mode 0: until queue drained and DUT idle; 1: until target rx words; 2: until target SCK rises; else run out.
   task automatic observe(input int max_cyc, input int mode, input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         cyc++;
         if (tx_valid && p_ready) void'(txq.pop_front());
         if (txq.size() > 0) begin
            tx_valid = 1'b1; tx_word = txq[0].w; hold_cs = txq[0].h;
         end else begin
            tx_valid = 1'b0; tx_word = '0; hold_cs = live_hold;
         end
         if (!cs && p_cs) begin
            cs_falls++;
            if (cs_rise_at >= 0) high_len.push_back(cyc - cs_rise_at);
            cs_fall_at = cyc; ref_cyc = cyc;
         end
         if (cs && !p_cs) begin
            low_len.push_back(cyc - cs_fall_at);
            hold_gap.push_back(cyc - last_fall);
            cs_rise_at = cyc;
         end
         if (sck && !p_sck) begin
            if (rises % W == 0) start_gap.push_back(cyc - ref_cyc);
            rises++;
            copi_bits = {copi_bits[126:0], copi};
         end
         if (!sck && p_sck) begin
            last_fall = cyc;
            if (rises % W == 0) ref_cyc = cyc;
         end
         if (rx_valid) rxq.push_back(rx_word);
         if (tx_ready && busy && cs) gap_ready_bad++;
         if (busy) seen_busy = 1'b1;
         p_sck = sck; p_cs = cs; p_ready = tx_ready;
         if (mode == 0 && seen_busy && !busy && txq.size() == 0 && !tx_valid) begin ok = 1'b1; break; end
         if (mode == 1 && rxq.size() >= target) begin ok = 1'b1; break; end
         if (mode == 2 && rises >= target) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (cs !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b expected 1", cs); end
      checks++; if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", sck); end
      checks++; if (copi !== 1'b0) begin errors++; $display("FAIL reset_copi: got %b expected 0", copi); end
      checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b expected 0", tx_ready); end
      checks++; if (rx_word !== '0 || rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx: got %h/%b expected 0/0", rx_word, rx_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (tx_ready !== 1'b1 || s_tx_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b/%b expected 1/1", tx_ready, s_tx_ready); end
      p_ready = tx_ready; p_sck = sck; p_cs = cs;
   endtask

   task automatic test_single();
      item_t it; bit ok;
      clear_stats(); cipo_mode = 0;
      it.w = 64'hDEAD_BEEF_0123_4567; it.h = 1'b0; txq.push_back(it);
      observe(3000, 0, 0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got busy=%b expected idle", busy); end
      checks++; if (rises !== W) begin errors++; $display("FAIL single_rises: got %0d expected %0d", rises, W); end
      checks++; if (copi_bits[W-1:0] !== it.w) begin errors++; $display("FAIL single_copi: got %h expected %h", copi_bits[W-1:0], it.w); end
      checks++; if (low_len.size() != 1 || low_len[0] != SU + 2*CD*W + HO) begin errors++; $display("FAIL single_cs_low: got %0d expected %0d", low_len.size() ? low_len[0] : -1, SU + 2*CD*W + HO); end
      checks++; if (rxq.size() != 1 || rxq[0] !== it.w) begin errors++; $display("FAIL single_rx: got %0d words first %h expected 1 word %h", rxq.size(), rxq.size() ? rxq[0] : '0, it.w); end
      checks++; if (start_gap.size() != 1 || start_gap[0] != SU + CD) begin errors++; $display("FAIL single_setup: got %0d expected %0d", start_gap.size() ? start_gap[0] : -1, SU + CD); end
      checks++; if (hold_gap.size() != 1 || hold_gap[0] != HO) begin errors++; $display("FAIL single_hold: got %0d expected %0d", hold_gap.size() ? hold_gap[0] : -1, HO); end
   endtask

   task automatic test_chain();
      item_t it; bit ok;
      clear_stats(); cipo_mode = 1;
      it.w = 64'h1; it.h = 1'b1; txq.push_back(it);
      it.w = 64'h2; it.h = 1'b0; txq.push_back(it);
      observe(3000, 0, 0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL chain_timeout: got busy=%b expected idle", busy); end
      checks++; if (cs_falls != 1) begin errors++; $display("FAIL chain_cs_falls: got %0d expected 1", cs_falls); end
      checks++; if (rises !== 2*W) begin errors++; $display("FAIL chain_rises: got %0d expected %0d", rises, 2*W); end
      checks++; if (start_gap.size() != 2 || start_gap[1] != 1 + CD) begin errors++; $display("FAIL chain_no_setup: got %0d expected %0d", start_gap.size() > 1 ? start_gap[1] : -1, 1 + CD); end
      checks++; if (rxq.size() != 2 || rxq[0] !== ~64'h1 || rxq[1] !== ~64'h2) begin errors++; $display("FAIL chain_rx: got %0d words expected 2 inverted words", rxq.size()); end
      checks++; if (hold_gap.size() != 1 || hold_gap[0] != HO) begin errors++; $display("FAIL chain_hold: got %0d expected %0d", hold_gap.size() ? hold_gap[0] : -1, HO); end
      checks++; if (low_len.size() != 1 || low_len[0] != SU + 4*CD*W + 1 + HO) begin errors++; $display("FAIL chain_cs_low: got %0d expected %0d", low_len.size() ? low_len[0] : -1, SU + 4*CD*W + 1 + HO); end
   endtask

   task automatic test_back_to_back();
      item_t it; bit ok; logic [W-1:0] exp_rx[$];
      clear_stats(); cipo_mode = 0;
      for (int i = 0; i < 3; i++) begin
         it.w = {$urandom, $urandom}; it.h = 1'b0; txq.push_back(it); exp_rx.push_back(it.w);
      end
      observe(5000, 0, 0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got busy=%b expected idle", busy); end
      checks++; if (cs_falls != 3 || high_len.size() != 2) begin errors++; $display("FAIL b2b_transactions: got %0d falls expected 3", cs_falls); end
      foreach (high_len[i]) begin
         checks++; if (high_len[i] < GP) begin errors++; $display("FAIL b2b_cs_gap: got %0d expected >= %0d", high_len[i], GP); end
      end
      checks++; if (gap_ready_bad != 0) begin errors++; $display("FAIL b2b_ready_in_gap: got %0d cycles expected 0", gap_ready_bad); end
      checks++; if (rxq.size() != 3) begin errors++; $display("FAIL b2b_rx_count: got %0d expected 3", rxq.size()); end
      for (int i = 0; i < 3 && i < rxq.size(); i++) begin
         checks++; if (rxq[i] !== exp_rx[i]) begin errors++; $display("FAIL b2b_rx%0d: got %h expected %h", i, rxq[i], exp_rx[i]); end
      end
   endtask

   task automatic test_random();
      item_t it; bit ok; logic [W-1:0] exp_rx[$]; int exp_low[$]; int k;
      clear_stats(); cipo_mode = $urandom_range(0, 1); k = 0;
      for (int i = 0; i < 5; i++) begin
         it.w = {$urandom, $urandom};
         it.h = (i == 4) ? 1'b0 : 1'($urandom_range(0, 1));
         txq.push_back(it);
         exp_rx.push_back(cipo_mode == 1 ? ~it.w : it.w);
         k++;
         if (!it.h) begin exp_low.push_back(SU + k*2*CD*W + (k - 1) + HO); k = 0; end
      end
      observe(8000, 0, 0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_timeout: got busy=%b expected idle", busy); end
      checks++; if (rxq.size() != 5 || low_len.size() != exp_low.size()) begin errors++; $display("FAIL rand_counts: got %0d/%0d expected 5/%0d", rxq.size(), low_len.size(), exp_low.size()); end
      for (int i = 0; i < rxq.size() && i < 5; i++) begin
         checks++; if (rxq[i] !== exp_rx[i]) begin errors++; $display("FAIL rand_rx%0d: got %h expected %h", i, rxq[i], exp_rx[i]); end
      end
      for (int i = 0; i < low_len.size() && i < exp_low.size(); i++) begin
         checks++; if (low_len[i] != exp_low[i]) begin errors++; $display("FAIL rand_cs_low%0d: got %0d expected %0d", i, low_len[i], exp_low[i]); end
      end
   endtask

   task automatic test_chain_idle();
      item_t it; bit ok; int bad, n;
      clear_stats(); cipo_mode = 0; live_hold = 1'b1;
      it.w = {$urandom, $urandom}; it.h = 1'b1; txq.push_back(it);
      observe(3000, 1, 1, ok);
      checks++; if (!ok || rxq[0] !== it.w) begin errors++; $display("FAIL idle_chain_rx: got %h expected %h", rxq.size() ? rxq[0] : '0, it.w); end
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         observe(1, 9, 0, ok);
         if (cs !== 1'b0 || sck !== 1'b0 || tx_ready !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL idle_chain_hold: got %0d bad cycles expected 0", bad); end
      live_hold = 1'b0; hold_cs = 1'b0; n = 0;
      for (int i = 0; i < 20; i++) begin
         observe(1, 9, 0, ok);
         n++;
         if (cs) break;
      end
      checks++; if (n != HO + 1 || !cs) begin errors++; $display("FAIL idle_chain_release: got %0d cycles expected %0d", n, HO + 1); end
      observe(20, 0, 0, ok);
   endtask

   task automatic test_reset_mid();
      item_t it; bit ok;
      clear_stats(); cipo_mode = 0;
      it.w = {$urandom, $urandom}; it.h = 1'b0; txq.push_back(it);
      observe(3000, 2, 31, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach: got %0d rises expected 31", rises); end
      reset = 1'b1;
      observe(1, 9, 0, ok);
      checks++; if (cs !== 1'b1 || sck !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_pins: got cs=%b sck=%b busy=%b expected 1 0 0", cs, sck, busy); end
      reset = 1'b0;
      observe(40, 9, 0, ok);
      checks++; if (rxq.size() != 0) begin errors++; $display("FAIL rstmid_no_rx: got %0d words expected 0", rxq.size()); end
      clear_stats();
      it.w = 64'hA5A5_A5A5_A5A5_A5A5; txq.push_back(it);
      observe(3000, 0, 0, ok);
      checks++; if (!ok || rxq.size() != 1 || rxq[0] !== it.w || rises != W) begin errors++; $display("FAIL rstmid_after: got %0d words %h rises %0d expected %h", rxq.size(), rxq.size() ? rxq[0] : '0, rises, it.w); end
   endtask

   task automatic test_small();
      int rx_k, bad, nr; logic [7:0] bits; logic [7:0] got;
      rx_k = -1; bad = 0; nr = 0; bits = '0; got = '0;
      @(negedge clk);
      checks++; if (s_tx_ready !== 1'b1) begin errors++; $display("FAIL small_ready: got %b expected 1", s_tx_ready); end
      s_tx_word = 8'h81; s_tx_valid = 1'b1; s_hold = 1'b0;
      @(negedge clk);
      s_tx_valid = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (k >= 2 && k < 18) begin
            if (s_sck !== 1'((k - 2) % 2)) bad++;
            if (s_sck) begin bits = {bits[6:0], s_copi}; nr++; end
         end
         if (s_rx_valid) begin rx_k = k; got = s_rx_word; break; end
         @(negedge clk);
      end
      checks++; if (bad != 0 || nr != 8) begin errors++; $display("FAIL small_sck_toggle: got %0d bad %0d rises expected 0 bad 8 rises", bad, nr); end
      checks++; if (bits !== 8'h81) begin errors++; $display("FAIL small_copi: got %h expected 81", bits); end
      checks++; if (rx_k != SU + 16) begin errors++; $display("FAIL small_latency: got %0d expected %0d", rx_k, SU + 16); end
      checks++; if (got !== 8'hFF) begin errors++; $display("FAIL small_rx: got %h expected ff", got); end
      repeat (10) @(negedge clk);
      p_sck = sck; p_cs = cs; p_ready = tx_ready;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; tx_word = '0; tx_valid = 1'b0; hold_cs = 1'b0; live_hold = 1'b0; cipo_mode = 0;
      s_tx_word = '0; s_tx_valid = 1'b0; s_hold = 1'b0;
      p_sck = 1'b0; p_cs = 1'b1; p_ready = 1'b0;
      test_reset();
      test_single();
      test_chain();
      test_back_to_back();
      test_chain_idle();
      test_reset_mid();
      test_random();
      test_small();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_initiator.md
Name: spi_initiator

Overview:
- SPI mode-0 initiator (controller), MSB first. It is the other end of the rapcore SPI responder.
- It serialises fixed-width command/payload words onto SCK/CS/COPI and captures CIPO in full duplex.
- It is instantiated in the test harness to drive rapcore, and is reusable on boards where the FPGA commands a downstream SPI device.
- A ready/valid word interface lets a sequencer stream multi-word transactions under a single CS assertion.

Parameters:
- WORD_BITS, 64, bits per word shifted per transfer (>=2).
- CLK_DIV, 4, CLK cycles per SCK half-period (>=1).
- CS_SETUP, 2, CLK cycles between CS falling and first SCK half-period (>=1).
- CS_HOLD, 2, CLK cycles between last SCK falling edge and CS rising (>=1).
- CS_GAP, 2, minimum CLK cycles CS stays high before the next transaction (>=1).

Ports:
- CLK  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tx_word  input  WORD_BITS  word to transmit
- tx_valid  input  1  tx_word is presented
- tx_ready  output  1  initiator accepts a word this cycle
- hold_cs  input  1  sampled with tx_word; 1 = keep CS low after this word
- rx_word  output  WORD_BITS  last full word received on CIPO
- rx_valid  output  1  one-cycle pulse when rx_word updates
- busy  output  1  CS asserted or timing phase in progress
- SCK  output  1  serial clock, idles low
- CS  output  1  chip select, active low
- COPI  output  1  controller-out data
- CIPO  input  1  controller-in data

Behaviour:
- Reset values: CS=1, SCK=0, COPI=0, tx_ready=0 during reset, rx_word=0, rx_valid=0, busy=0. FSM enters IDLE. Counters clear.
- Reset asserted mid-word: the next edge forces CS=1 and SCK=0. No rx_valid is emitted for the partial word, and no CS_HOLD phase runs.
- Handshake: a word is accepted when tx_valid && tx_ready on a CLK edge. tx_word and hold_cs are latched then, and tx_ready is 1 only in IDLE and CHAIN.
- States:
  - IDLE: CS=1, tx_ready=1. On accept: load tx_shift, bit_cnt=WORD_BITS-1, COPI=tx_word[WORD_BITS-1], CS->0, go SETUP.
  - SETUP: hold for CS_SETUP cycles, then go LOW.
  - LOW: SCK=0 for CLK_DIV cycles, then go HIGH.
  - HIGH: SCK=1 for CLK_DIV cycles. On the first HIGH cycle (the SCK rising edge) CIPO is shifted into rx_shift at bit 0.
  - End of HIGH with bit_cnt>0: shift tx_shift left, COPI=next bit, decrement bit_cnt, go LOW.
  - End of HIGH with bit_cnt=0: SCK->0, rx_word<=rx_shift, rx_valid=1 for one cycle. Go CHAIN if latched hold_cs=1, else go TAIL.
  - CHAIN: CS=0, SCK=0, tx_ready=1. An accept loads the word and goes LOW directly (no SETUP). If there is no tx_valid and live hold_cs=0, go TAIL.
  - Simultaneous tx_valid and hold_cs=0 in CHAIN: the word is accepted; its latched hold_cs decides the following state.
  - TAIL: CS=0 for CS_HOLD cycles, then CS->1, go GAP.
  - GAP: CS=1 for CS_GAP cycles, then go IDLE.
- Timing per word: exactly 2*CLK_DIV*WORD_BITS cycles from entering LOW to rx_valid.
  - Single-word transaction: CS low for CS_SETUP + 2*CLK_DIV*WORD_BITS + CS_HOLD cycles.
- COPI changes only on SCK falling edges or at load, so it is stable for CLK_DIV cycles before each rising edge.
- busy = (state != IDLE).
- rx_word holds its value until the next completed word.
- bit_cnt width is $clog2(WORD_BITS). Divider and phase counters are sized from the maximum of CLK_DIV, CS_SETUP, CS_HOLD and CS_GAP.
- CIPO is sampled directly without a synchroniser; it is launched by the responder from this block's own SCK.

Decomposition:
- State encodings (IDLE, SETUP, LOW, HIGH, CHAIN, TAIL, GAP) go as localparams in src/constants.v alongside the existing SPI constants.
- One natural sub-module, spi_initiator_timer: a loadable down-counter with a done flag. It is shared by the SETUP/LOW/HIGH/TAIL/GAP phases.

Test Plan:
1. Default params, send 64'hDEAD_BEEF_0123_4567 with hold_cs=0, responder looped (CIPO=COPI delayed half-period):
   - exactly 64 SCK rising edges;
   - COPI bits match MSB first;
   - CS low for 2+512+2 cycles;
   - one rx_valid with rx_word=64'hDEAD_BEEF_0123_4567.
2. Chained: words 64'h1 (hold_cs=1) then 64'h2 (hold_cs=0):
   - CS stays low between them;
   - no SETUP before word 2;
   - 128 SCK edges total;
   - two rx_valid pulses;
   - CS rises CS_HOLD cycles after the last SCK fall.
3. Back-to-back single words:
   - tx_ready stays low through GAP;
   - CS high at least CS_GAP=2 cycles between transactions.
4. CHAIN with no valid for 50 cycles:
   - CS held low, SCK idle at 0;
   - deasserting hold_cs goes TAIL -> CS high after 2 cycles.
5. Reset asserted at bit 30:
   - next cycle CS=1, SCK=0;
   - no rx_valid;
   - a subsequent word 64'hA5A5... transfers correctly.
6. CLK_DIV=1, WORD_BITS=8, send 8'h81 with CIPO tied high:
   - SCK toggles every cycle;
   - rx_word=8'hFF after 16 cycles from LOW.
